vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing.sv | 80 ++++++++
 tb/tb_vga_timing.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// VGA timing constants and coordinate type shared with drawing stages.
// Defaults describe standard 640x480 @ 60 Hz (25.175 MHz pixel clock).
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_span(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with registered sync, blanking and start strobes.
// Outputs are derived from next-count values so they align with x_px/y_px.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   px_en,
  output coord_t x_px,
  output coord_t y_px,
  output logic   hsync,
  output logic   vsync,
  output logic   activevideo,
  output logic   line_start,
  output logic   frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t X_LAST = COORD_W'(H_TOT - 1);
  localparam coord_t Y_LAST = COORD_W'(V_TOT - 1);
  localparam coord_t HS_LO  = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t X_VIS  = COORD_W'(H_ACTIVE);
  localparam coord_t Y_VIS  = COORD_W'(V_ACTIVE);

  coord_t x_next;
  coord_t y_next;
  logic   x_wrap;

  // Compare before incrementing so no value ever passes the last count.
  always_comb begin
    x_wrap = (x_px == X_LAST);
    x_next = x_wrap ? '0 : x_px + 1'b1;
    y_next = y_px;
    if (x_wrap) begin
      y_next = (y_px == Y_LAST) ? '0 : y_px + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_px        <= X_LAST;
      y_px        <= Y_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      activevideo <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (px_en) begin
        x_px        <= x_next;
        y_px        <= y_next;
        hsync       <= in_span(x_next, HS_LO, HS_HI)
                       ? SYNC_POL : ~SYNC_POL;
        vsync       <= in_span(y_next, VS_LO, VS_HI)
                       ? SYNC_POL : ~SYNC_POL;
        activevideo <= (x_next < X_VIS) && (y_next < Y_VIS);
        line_start  <= (x_next == '0);
        frame_start <= (x_next == '0) && (y_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 instance plus a tiny-geometry
// instance, both checked against a frame-index arithmetic model.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, en_d, rst_s, en_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic hs_d, vs_d, av_d, ls_d, fs_d;
  logic hs_s, vs_s, av_s, ls_s, fs_s;

  int checks = 0;
  int failures = 0;

  int k_d, k_s;
  bit last_d, last_s;

  vga_timing dut_d (
    .clk(clk), .reset_n(rst_d), .px_en(en_d),
    .x_px(x_d), .y_px(y_d), .hsync(hs_d), .vsync(vs_d),
    .activevideo(av_d), .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset_n(rst_s), .px_en(en_s),
    .x_px(x_s), .y_px(y_s), .hsync(hs_s), .vsync(vs_s),
    .activevideo(av_s), .line_start(ls_s), .frame_start(fs_s)
  );

  logic [24:0] obs_d, obs_s;
  assign obs_d = {x_d, y_d, hs_d, vs_d, av_d, ls_d, fs_d};
  assign obs_s = {x_s, y_s, hs_s, vs_s, av_s, ls_s, fs_s};

  // k counts enabled edges since reset; k=0 is the reset position.
  always @(posedge clk or negedge rst_d)
    if (!rst_d) begin
      k_d <= 0; last_d <= 1'b0;
    end else begin
      last_d <= en_d;
      if (en_d) k_d <= k_d + 1;
    end

  always @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      k_s <= 0; last_s <= 1'b0;
    end else begin
      last_s <= en_s;
      if (en_s) k_s <= k_s + 1;
    end

  function automatic logic [24:0] model(
    input int k, input bit last,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb
  );
    int ht, vt, f, p, x, y;
    bit hsn, vsn, av, ls, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    f  = ht * vt;
    p  = ((k % f) + f - 1) % f;
    x  = p % ht;
    y  = p / ht;
    hsn = !(x >= ha + hf && x < ha + hf + hs);
    vsn = !(y >= va + vf && y < va + vf + vs);
    av  = (x < ha) && (y < va);
    ls  = last && (x == 0);
    fs  = ls && (y == 0);
    return {10'(x), 10'(y), hsn, vsn, av, ls, fs};
  endfunction

  function automatic logic [24:0] exp_d();
    return model(k_d, last_d, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [24:0] exp_s();
    return model(k_s, last_s, 8, 2, 2, 2, 4, 1, 1, 1);
  endfunction

  task automatic test_reset();
    logic [24:0] rd, rs;
    rd = {10'd799, 10'd524, 1'b1, 1'b1, 3'b000};
    rs = {10'd13, 10'd6, 1'b1, 1'b1, 3'b000};
    #2;
    rst_d = 1'b0;
    rst_s = 1'b0;
    #1;
    checks++;
    if (obs_d !== rd) begin
      failures++;
      $display("FAIL reset_async_d got=%h exp=%h", obs_d, rd);
    end
    en_d = 1'b1;
    en_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_d !== rd) begin
      failures++;
      $display("FAIL reset_hold_d got=%h exp=%h", obs_d, rd);
    end
    checks++;
    if (obs_s !== rs) begin
      failures++;
      $display("FAIL reset_hold_s got=%h exp=%h", obs_s, rs);
    end
    en_s = 1'b0;
  endtask

  task automatic test_release();
    logic [24:0] e;
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    rst_d = 1'b1;
    en_d  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs_d !== e) begin
      failures++;
      $display("FAIL release_first got=%h exp=%h", obs_d, e);
    end
  endtask

  task automatic test_line();
    int cyc = 0, last_ls = -1, lo_start = -1;
    int n_ls = 0, n_hs = 0;
    bit prev_hs = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (obs_d !== exp_d()) begin
        failures++;
        $display("FAIL line_model got=%h exp=%h", obs_d, exp_d());
      end
      if (ls_d) begin
        n_ls++;
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != 800) begin
            failures++;
            $display("FAIL ls_period got=%0d exp=800", cyc - last_ls);
          end
        end
        last_ls = cyc;
      end
      if (!hs_d && prev_hs) begin
        checks++;
        if (x_d !== 10'd656) begin
          failures++;
          $display("FAIL hs_start got=%0d exp=656", x_d);
        end
        lo_start = cyc;
      end
      if (hs_d && !prev_hs && lo_start >= 0) begin
        n_hs++;
        checks++;
        if (cyc - lo_start != 96) begin
          failures++;
          $display("FAIL hs_width got=%0d exp=96", cyc - lo_start);
        end
      end
      prev_hs = hs_d;
    end
    checks++;
    if (n_ls != 2 || n_hs != 2) begin
      failures++;
      $display("FAIL line_pulses got=%0d/%0d exp=2/2", n_ls, n_hs);
    end
  endtask

  task automatic test_async_reset();
    logic [24:0] rd, e0;
    bit found = 1'b0;
    rd = {10'd799, 10'd524, 1'b1, 1'b1, 3'b000};
    e0 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 900 && !found; i++) begin
      @(posedge clk);
      #1;
      if (x_d == 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_300 got=%0d exp=300", x_d);
    end
    #2;
    rst_d = 1'b0;
    #1;
    checks++;
    if (obs_d !== rd) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=%h", obs_d, rd);
    end
    @(negedge clk);
    rst_d = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs_d !== e0) begin
      failures++;
      $display("FAIL restart got=%h exp=%h", obs_d, e0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs_d !== exp_d() || ls_d !== 1'b0) begin
      failures++;
      $display("FAIL restart_next got=%h exp=%h", obs_d, exp_d());
    end
    en_d = 1'b0;
  endtask

  task automatic test_small_frames();
    int cyc = 0, last_fs = -1, n_fr = 0;
    int vs_cnt = 0, av_cnt = 0, xmax = 0, ymax = 0;
    @(negedge clk);
    rst_s = 1'b1;
    en_s  = 1'b1;
    for (int i = 0; i < 3 * 98 + 1; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (obs_s !== exp_s()) begin
        failures++;
        $display("FAIL small_model got=%h exp=%h", obs_s, exp_s());
      end
      checks++;
      if (hs_s !== !(x_s == 10'd10 || x_s == 10'd11) ||
          vs_s !== (y_s != 10'd5)) begin
        failures++;
        $display("FAIL small_sync got=%b%b exp_x=%0d y=%0d",
                 hs_s, vs_s, x_s, y_s);
      end
      if (fs_s) begin
        if (last_fs >= 0) begin
          n_fr++;
          checks++;
          if (cyc - last_fs != 98 || vs_cnt != 14 || av_cnt != 32) begin
            failures++;
            $display("FAIL small_frame got=%0d/%0d/%0d exp=98/14/32",
                     cyc - last_fs, vs_cnt, av_cnt);
          end
        end
        last_fs = cyc;
        vs_cnt = 0;
        av_cnt = 0;
      end
      if (!vs_s) vs_cnt++;
      if (av_s) av_cnt++;
      if (int'(x_s) > xmax) xmax = int'(x_s);
      if (int'(y_s) > ymax) ymax = int'(y_s);
    end
    checks++;
    if (xmax != 13 || ymax != 6 || n_fr != 3) begin
      failures++;
      $display("FAIL small_wrap got=%0d/%0d/%0d exp=13/6/3",
               xmax, ymax, n_fr);
    end
  endtask

  task automatic test_toggle();
    logic [24:0] prev;
    int cyc = 0, last_fs = -1, n_fs = 0;
    bit prev_fs = 1'b0;
    for (int i = 0; i < 4 * 98; i++) begin
      @(negedge clk);
      en_s = i[0];
      prev = obs_s;
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (obs_s !== exp_s()) begin
        failures++;
        $display("FAIL toggle_model got=%h exp=%h", obs_s, exp_s());
      end
      if (!en_s) begin
        checks++;
        if (obs_s[24:2] !== prev[24:2] || obs_s[1:0] !== 2'b00) begin
          failures++;
          $display("FAIL toggle_hold got=%h exp=%h", obs_s, prev);
        end
      end
      if (prev_fs) begin
        checks++;
        if (fs_s !== 1'b0) begin
          failures++;
          $display("FAIL fs_width got=%b exp=0", fs_s);
        end
      end
      if (fs_s) begin
        n_fs++;
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != 196) begin
            failures++;
            $display("FAIL fs_period got=%0d exp=196", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
      prev_fs = fs_s;
    end
    checks++;
    if (n_fs < 2) begin
      failures++;
      $display("FAIL toggle_fs_count got=%0d exp>=2", n_fs);
    end
  endtask

  task automatic test_random();
    logic [24:0] rs, e0;
    bit found = 1'b0;
    rs = {10'd13, 10'd6, 1'b1, 1'b1, 3'b000};
    e0 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en_s = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if (obs_s !== exp_s()) begin
        failures++;
        $display("FAIL random_model got=%h exp=%h", obs_s, exp_s());
      end
    end
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      en_s = 1'b1;
      @(posedge clk);
      #1;
      if (!hs_s) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_hsync got=%b exp=0", hs_s);
    end
    #2;
    rst_s = 1'b0;
    #1;
    checks++;
    if (obs_s !== rs) begin
      failures++;
      $display("FAIL sync_abort got=%h exp=%h", obs_s, rs);
    end
    @(negedge clk);
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs_s !== e0) begin
      failures++;
      $display("FAIL small_restart got=%h exp=%h", obs_s, e0);
    end
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    en_d  = 1'b0;
    en_s  = 1'b0;
    test_reset();
    test_release();
    test_line();
    test_async_reset();
    test_small_frames();
    test_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
